apb_regfile_slave: RTL and testbench
====================================

# apb_regfile_slave

APB slave that terminates transfers issued by the team's APB master: a bank of NUM_REGS read/write 32-bit registers plus one read-only write-count status register. Each access takes a programmable number of wait states. The slave drives PREADY, PRDATA and PSLVERR back to the master. It sits directly downstream of the master on the PSEL/PENABLE/PWRITE/PADDR/PWDATA bus.

## Interface
- NUM_REGS, 8: number of RW registers, at word addresses 0 .. NUM_REGS-1 (byte address = 4*index).
- WAIT_CYCLES, 1: wait states inserted before PREADY; range 0..15.
- CNT_W, 32: width of the write counter, 1..32, zero-extended on read.

Ports:
- PCLK  in  1  clock; all state changes on its rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- PSEL  in  1  slave select from the master.
- PENABLE  in  1  access-phase strobe from the master.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; registered.
- PREADY  out  1  transfer-complete pulse; registered.
- PSLVERR  out  1  error flag; valid only while PREADY=1, else 0.

## Operation
- Address map:
  - Index i = PADDR[31:2].
  - i < NUM_REGS selects REG[i] (RW).
  - i == NUM_REGS selects STATUS = zero-extended WRCNT (read-only).
  - Every other address is invalid.
- Error conditions (PSLVERR=1):
  - PADDR[1:0] != 0.
  - Invalid index.
  - Write to STATUS.
  - On error: no register or counter changes, PRDATA driven 0.
- FSM states:
  - IDLE: on an edge sampling PSEL=1 and PENABLE=1, latch PWRITE/PADDR/PWDATA into internal capture registers, load wait counter WC = WAIT_CYCLES, go to WAIT. PSEL=1 with PENABLE=0 (setup phase) causes no action.
  - WAIT: if PSEL=0 at the edge, abort to IDLE with no commit and no PREADY. Else if WC==0, go to RESP. Else WC decrements.
  - RESP: PREADY=1 for exactly this one cycle, then unconditionally go to IDLE.
- Commit on the edge entering RESP:
  - Valid write: REG[i] <= captured PWDATA; WRCNT <= WRCNT+1 modulo 2^CNT_W.
  - Valid read: PRDATA <= REG[i] or STATUS.
  - PRDATA holds its value until the next read commit. Writes leave PRDATA unchanged, except that an errored access drives it to 0.
- Only captured values are used. Bus changes after the capture edge are ignored.
- After RESP the slave spends at least one cycle in IDLE. A master still holding PSEL/PENABLE high is therefore sampled again as a new transfer on the following edge.

## Timing
- Reset values:
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - All REG=0, WRCNT=0, FSM=IDLE, WC=0.
  - Reset takes effect immediately (asynchronous) and aborts any transfer in flight with no commit.
- Latency: if the access is sampled at edge E, PREADY rises at edge E+WAIT_CYCLES+1 and falls at edge E+WAIT_CYCLES+2.
- PRDATA and PSLVERR are updated on the same edge PREADY rises. A master capturing PRDATA on the rising edge of PREADY must see the new value.
- Back-to-back transfers: minimum spacing is WAIT_CYCLES+3 cycles from one capture edge to the next (capture, WAIT_CYCLES wait states, RESP, IDLE).
- Abort: PSEL=0 in WAIT returns to IDLE at that edge. PREADY stays 0 and no state changes.
- WRCNT wrap: all-ones +1 becomes 0. No saturation and no flag.

## Test plan
- Reset: assert PRESET mid-WAIT -> PREADY/PSLVERR/PRDATA go to 0 immediately; a subsequent read of 0x8 returns 0x00000000.
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x4 sampled at edge E -> PREADY high only during E+3..E+4, PSLVERR=0. Read 0x4 -> PRDATA=0xDEADBEEF when PREADY rises; STATUS reads 0x1.
- Errors:
  - Read 0x40 (NUM_REGS=8, index 16) -> PREADY pulse with PSLVERR=1, PRDATA=0.
  - Write 0x6 (misaligned) -> PSLVERR=1; REG[1] unchanged.
- Read-only status: write 0x12345678 to 0x20 -> PSLVERR=1; STATUS read is unchanged.
- Abort: drop PSEL during WAIT with WAIT_CYCLES=3 -> no PREADY pulse, target REG unchanged, WRCNT unchanged.
- Wrap, CNT_W=4, WAIT_CYCLES=0: 16 valid writes -> STATUS reads 0x0; the 17th write -> STATUS reads 0x1. Each PREADY arrives 1 cycle after access.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB slave: NUM_REGS RW registers plus a read-only write-count status word.
// Each access inserts WAIT_CYCLES wait states before a one-cycle PREADY pulse.
module apb_regfile_slave #(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [29:0] NR = 30'(NUM_REGS);
  localparam logic [3:0]  WC_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_wc;
  logic               r_wr;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_regs [NUM_REGS];
  logic [CNT_W-1:0]   r_wrcnt;

  logic               w_capture;
  logic               w_commit;
  logic [29:0]        w_idx;
  logic               w_is_reg;
  logic               w_is_stat;
  logic               w_err;
  logic [31:0]        w_status;
  logic [31:0]        w_rdata;

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (PSEL && PENABLE) begin
          w_capture = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          w_next = S_IDLE;
        end else if (r_wc == 4'd0) begin
          w_commit = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Decode works only on captured bus values.
  always_comb begin
    w_idx     = r_addr[31:2];
    w_is_reg  = (w_idx < NR);
    w_is_stat = (w_idx == NR);
    w_err     = (r_addr[1:0] != 2'b00)
              || !(w_is_reg || w_is_stat)
              || (w_is_stat && r_wr);
    w_status  = '0;
    w_status[CNT_W-1:0] = r_wrcnt;
    w_rdata   = '0;
    if (w_is_stat) w_rdata = w_status;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == 30'(i)) w_rdata = r_regs[i];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
      r_wc    <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wrcnt <= '0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      r_state <= w_next;
      PREADY  <= w_commit;
      PSLVERR <= w_commit && w_err;
      if (w_capture) begin
        r_wr    <= PWRITE;
        r_addr  <= PADDR;
        r_wdata <= PWDATA;
        r_wc    <= WC_LOAD;
      end else if (r_state == S_WAIT && r_wc != 4'd0) begin
        r_wc <= r_wc - 4'd1;
      end
      if (w_commit) begin
        if (w_err) begin
          PRDATA <= '0;
        end else if (r_wr) begin
          r_wrcnt <= r_wrcnt + CNT_W'(1);
        end else begin
          PRDATA <= w_rdata;
        end
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && !w_err && r_wr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == 30'(i)) r_regs[i] <= r_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: three instances with different
// wait-state and counter-width settings share one bus, each with its own PSEL.
module tb_apb_regfile_slave;

  logic        PCLK;
  logic        PRESET;
  logic [2:0]  psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;

  logic [31:0] rd_a, rd_b, rd_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        err_a, err_b, err_c;

  int tests;
  int fails;

  apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(2), .CNT_W(32)) u_a (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(rd_a), .PREADY(rdy_a), .PSLVERR(err_a));

  apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(3), .CNT_W(32)) u_b (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(rd_b), .PREADY(rdy_b), .PSLVERR(err_b));

  apb_regfile_slave #(.NUM_REGS(8), .WAIT_CYCLES(0), .CNT_W(4)) u_c (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(rd_c), .PREADY(rdy_c), .PSLVERR(err_c));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic logic rdy_of(input int i);
    case (i)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic err_of(input int i);
    case (i)
      0:       return err_a;
      1:       return err_b;
      default: return err_c;
    endcase
  endfunction

  function automatic logic [31:0] rd_of(input int i);
    case (i)
      0:       return rd_a;
      1:       return rd_b;
      default: return rd_c;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transfer; bus is scrambled after capture to prove it is ignored.
  task automatic xfer(input int inst, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int lat, output logic fell);
    @(posedge PCLK); #1;
    psel       = '0;
    psel[inst] = 1'b1;
    PENABLE    = 1'b0;
    PWRITE     = wr;
    PADDR      = a;
    PWDATA     = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PWRITE = ~wr;
    PADDR  = a ^ 32'h4;
    PWDATA = ~d;
    lat = -1;
    if (rdy_of(inst)) lat = 0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge PCLK); #1;
      if (rdy_of(inst)) lat = c;
    end
    rd = rd_of(inst);
    er = err_of(inst);
    psel    = '0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    fell = !rdy_of(inst);
  endtask

  typedef struct {
    int          inst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        fell;
    logic        seen;
    int          exp_lat;

    tests   = 0;
    fails   = 0;
    PRESET  = 1'b1;
    psel    = '0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;

    vecs[0]  = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{0, 1'b0, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 1'b0, 32'h20, 32'h0,        32'h00000001, 1'b0};
    vecs[3]  = '{0, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1};
    vecs[4]  = '{0, 1'b1, 32'h1C, 32'h11112222, 32'h0,        1'b0};
    vecs[5]  = '{0, 1'b0, 32'h1C, 32'h0,        32'h11112222, 1'b0};
    vecs[6]  = '{0, 1'b1, 32'h06, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[7]  = '{0, 1'b0, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[8]  = '{0, 1'b1, 32'h20, 32'h12345678, 32'h0,        1'b1};
    vecs[9]  = '{0, 1'b0, 32'h20, 32'h0,        32'h00000002, 1'b0};
    vecs[10] = '{0, 1'b0, 32'h24, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{0, 1'b1, 32'h08, 32'h0000A5A5, 32'h0,        1'b0};
    vecs[12] = '{0, 1'b0, 32'h03, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1, 1'b1, 32'h10, 32'h01020304, 32'h0,        1'b0};
    vecs[14] = '{1, 1'b0, 32'h10, 32'h0,        32'h01020304, 1'b0};
    vecs[15] = '{0, 1'b0, 32'h08, 32'h0,        32'h0000A5A5, 1'b0};

    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_prdata_a", rd_a, 32'h0);
    chk("reset_pready_a", {31'b0, rdy_a}, 32'h0);
    chk("reset_pslverr_a", {31'b0, err_a}, 32'h0);
    chk("reset_pready_c", {31'b0, rdy_c}, 32'h0);
    PRESET = 1'b0;

    for (int v = 0; v < 16; v++) begin
      exp_lat = (vecs[v].inst == 0) ? 3 : (vecs[v].inst == 1) ? 4 : 1;
      xfer(vecs[v].inst, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
           rd, er, lat, fell);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(exp_lat));
      chk($sformatf("vec%0d_pslverr", v), {31'b0, er},
          {31'b0, vecs[v].exp_err});
      chk($sformatf("vec%0d_prdata", v), rd, vecs[v].exp_rd);
      chk($sformatf("vec%0d_pready_fall", v), {31'b0, fell}, 32'h1);
    end

    // Abort on the 3-wait-state instance: PSEL drops mid-WAIT.
    @(posedge PCLK); #1;
    psel    = 3'b010;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h14;
    PWDATA  = 32'hAAAA5555;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    psel    = '0;
    PENABLE = 1'b0;
    seen    = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge PCLK); #1;
      if (rdy_b) seen = 1'b1;
    end
    chk("abort_no_pready", {31'b0, seen}, 32'h0);
    xfer(1, 1'b0, 32'h14, 32'h0, rd, er, lat, fell);
    chk("abort_reg_unchanged", rd, 32'h0);
    xfer(1, 1'b0, 32'h20, 32'h0, rd, er, lat, fell);
    chk("abort_wrcnt_unchanged", rd, 32'h1);

    // 4-bit write counter wraps after 16 writes.
    for (int k = 0; k < 16; k++) begin
      xfer(2, 1'b1, 32'((k % 8) * 4), 32'(k), rd, er, lat, fell);
      chk($sformatf("wrap_w%0d_latency", k), 32'(lat), 32'h1);
    end
    xfer(2, 1'b0, 32'h20, 32'h0, rd, er, lat, fell);
    chk("wrap_status_16", rd, 32'h0);
    xfer(2, 1'b1, 32'h00, 32'h77, rd, er, lat, fell);
    chk("wrap_w16_pslverr", {31'b0, er}, 32'h0);
    xfer(2, 1'b0, 32'h20, 32'h0, rd, er, lat, fell);
    chk("wrap_status_17", rd, 32'h1);
    xfer(2, 1'b0, 32'h1C, 32'h0, rd, er, lat, fell);
    chk("wrap_reg7_last", rd, 32'hF);

    // Asynchronous reset in the middle of a read of 0x8.
    @(posedge PCLK); #1;
    psel    = 3'b001;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 32'h08;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("prereset_prdata", rd_a, 32'h0000A5A5);
    #2;
    PRESET = 1'b1;
    #1;
    chk("async_reset_prdata", rd_a, 32'h0);
    chk("async_reset_pready", {31'b0, rdy_a}, 32'h0);
    chk("async_reset_pslverr", {31'b0, err_a}, 32'h0);
    psel    = '0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    xfer(0, 1'b0, 32'h08, 32'h0, rd, er, lat, fell);
    chk("after_reset_read8", rd, 32'h0);
    chk("after_reset_latency", 32'(lat), 32'h3);
    xfer(0, 1'b0, 32'h20, 32'h0, rd, er, lat, fell);
    chk("after_reset_status", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
